pll_reset_sequencer: RTL

Sequences the core's clock PLL and the system reset it feeds. Runs on the free-running 50 MHz reference clock. Holds the PLL in reset at power-up, waits for lock, and qualifies the lock as stable. Only then releases the system reset used by the 20 MHz and 10 MHz domains. On lock timeout it retries a bounded number of times; on loss of lock during operation it re-sequences.

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/pll_reset_sequencer_sync2.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and elaboration helpers for the PLL / system-reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  // Minimum counter width able to hold max(a, b, c) - 1.
  function automatic int cnt_w_min(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop bit synchroniser, cleared by synchronous reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, qualifies its lock, then releases the system reset;
// retries on lock timeout and re-sequences when lock drops in operation.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       seq_ok,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  if (CNT_W < cnt_w_min(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) begin : g_cnt_w_check
    $error("pll_reset_sequencer: CNT_W too small for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             lock_s;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rc_inc, rc_nxt;
  logic             counting;

  sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign rc_inc   = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
  assign counting = (state == S_PLL_RST) || (state == S_WAIT_LOCK) || (state == S_STABLE);

  // Lock is checked before the timeout so a rise on the timeout cycle wins.
  always_comb begin
    nxt    = state;
    rc_nxt = retry_cnt;
    case (state)
      S_PLL_RST:   if (cnt == PR_LAST) nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) nxt = S_STABLE;
        else if (cnt == TO_LAST) begin
          rc_nxt = rc_inc;
          nxt    = (int'(rc_inc) == MAX_RETRIES) ? S_FAIL : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!lock_s) nxt = S_WAIT_LOCK;
        else if (cnt == ST_LAST) nxt = S_RUN;
      end
      S_RUN:       if (!lock_s) nxt = S_PLL_RST;
      S_FAIL:      nxt = S_FAIL;
      default:     nxt = S_PLL_RST;
    endcase
    if (nxt == S_RUN && state != S_RUN) rc_nxt = 2'd0;
  end

  // Outputs are registered from the next state, so they track the state
  // register exactly and cannot glitch.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      seq_ok    <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      state     <= nxt;
      cnt       <= (nxt != state || !counting) ? '0 : cnt + CNT_W'(1);
      pll_rst   <= (nxt == S_PLL_RST) || (nxt == S_FAIL);
      sys_rst   <= (nxt != S_RUN);
      seq_ok    <= (nxt == S_RUN);
      fail      <= (nxt == S_FAIL);
      retry_cnt <= rc_nxt;
      if (state == S_RUN && !lock_s) lock_lost <= 1'b1;
    end
  end

endmodule
